serial_addsub: RTL



---
 rtl/addsub_pkg.sv | 25 ++
 rtl/addsub_digit.sv | 27 ++
 rtl/serial_addsub.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/addsub_pkg.sv
// Shared types and elaboration helpers for the serial adder/subtractor.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package addsub_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Digit counter width; at least one bit so a single-digit build still
   // has a legal counter.
   function automatic int cnt_width(input int width, input int digit);
      int n;
      n = width / digit;
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // The operand must split into a whole number of digits.
   function automatic bit digit_fits(input int width, input int digit);
      return (digit > 0) && (width >= digit) && ((width % digit) == 0);
   endfunction

endpackage

// File: rtl/addsub_digit.sv
// DIGIT-bit combinational ripple adder slice.
// Latency: combinational.
// Backpressure: none.
// Ports: x, y - digit operands; cin - carry in;
//        s - digit sum; cout - carry out of the top bit;
//        cmsb - carry into the top bit (for overflow detection).
module addsub_digit #(
   parameter int DIGIT = 1
) (
   input  logic [DIGIT-1:0] x,
   input  logic [DIGIT-1:0] y,
   input  logic             cin,
   output logic [DIGIT-1:0] s,
   output logic             cout,
   output logic             cmsb
);

   logic [DIGIT:0] full;

   assign full = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, cin};
   assign s    = full[DIGIT-1:0];
   assign cout = full[DIGIT];
   // Sum bit = x ^ y ^ carry_in, so the carry into the top bit falls out of
   // the top sum bit without a second adder.
   assign cmsb = s[DIGIT-1] ^ x[DIGIT-1] ^ y[DIGIT-1];

endmodule

// File: rtl/serial_addsub.sv
// Multi-cycle adder/subtractor, DIGIT bits per clock, LS digit first.
// Latency: start at edge k -> busy cycles k+1..k+N -> done pulse in cycle k+N+1.
// Backpressure: start is ignored while busy; no queueing; back-to-back from DONE.
// Ports: clock, reset (sync, active-high); start/sub/a/b request, sampled
//        when busy=0; busy, done (1-cycle pulse); sum/cout/ovf held until
//        the next done.
// Build option: define ADDSUB_SAT_EN to saturate sum on signed overflow.
module serial_addsub
   import addsub_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DIGIT = 1
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = cnt_width(WIDTH, DIGIT);

   generate
      if (!digit_fits(WIDTH, DIGIT)) begin : g_bad_digit
         $error("serial_addsub: WIDTH must be a non-zero multiple of DIGIT");
      end
   endgenerate

   state_t           state, state_nxt;
   logic             load;
   logic [WIDTH-1:0] a_sh;      // operand A, refilled from the top with result digits
   logic [WIDTH-1:0] b_sh;      // operand B (already inverted for subtract)
   logic             carry;
   logic [CW-1:0]    cnt;
   logic             last;

   logic [DIGIT-1:0] d_s;
   logic             d_cout;
   logic             d_cmsb;
   logic [WIDTH-1:0] a_nxt;
   logic [WIDTH-1:0] sum_nxt;
   logic             ovf_nxt;

   addsub_digit #(.DIGIT(DIGIT)) u_digit (
      .x    (a_sh[DIGIT-1:0]),
      .y    (b_sh[DIGIT-1:0]),
      .cin  (carry),
      .s    (d_s),
      .cout (d_cout),
      .cmsb (d_cmsb)
   );

   // As A's digits are consumed from the bottom, the result digits enter at
   // the top, so after N steps the register holds the full result.
   generate
      if (N == 1) begin : g_one_digit
         assign a_nxt = d_s;
      end else begin : g_multi_digit
         assign a_nxt = {d_s, a_sh[WIDTH-1:DIGIT]};
      end
   endgenerate

   assign last    = (cnt == CW'(N - 1));
   assign ovf_nxt = d_cmsb ^ d_cout;

`ifdef ADDSUB_SAT_EN
   // On overflow the true sign is the carry out: 0 -> clamp to max positive,
   // 1 -> clamp to most negative.
   always_comb begin
      sum_nxt = a_nxt;
      if (ovf_nxt) begin
         sum_nxt = d_cout ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
      end
   end
`else
   assign sum_nxt = a_nxt;
`endif

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end
         end
         RUN: begin
            if (last) state_nxt = DONE;
         end
         DONE: begin
            if (start) begin
               load      = 1'b1;
               state_nxt = RUN;
            end else begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         a_sh  <= '0;
         b_sh  <= '0;
         carry <= 1'b0;
         cnt   <= '0;
         sum   <= '0;
         cout  <= 1'b0;
         ovf   <= 1'b0;
      end else begin
         state <= state_nxt;
         if (load) begin
            // Subtract as a + ~b + 1: the +1 enters through the carry.
            a_sh  <= a;
            b_sh  <= sub ? ~b : b;
            carry <= sub;
            cnt   <= '0;
         end else if (state == RUN) begin
            a_sh  <= a_nxt;
            b_sh  <= b_sh >> DIGIT;
            carry <= d_cout;
            cnt   <= cnt + 1'b1;
            if (last) begin
               sum  <= sum_nxt;
               cout <= d_cout;
               ovf  <= ovf_nxt;
            end
         end
      end
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

endmodule
